pipe_stage_hs: RTL and testbench

Generic, parametrised pipeline stage register with valid/ready handshake, synchronous flush and a saturating back-pressure counter. It replaces the fixed-field, always-advancing stage registers between pipeline stages (F/D, D/E, E/M, M/W) so that stages can stall independently without global enable wiring. Callers pack their stage fields into one `WIDTH`-bit payload.

---
 rtl/pipe_stage_hs_pkg.sv | 19 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stage_hs.sv | 119 +++++++++++
 tb/tb_pipe_stage_hs.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared pipeline types: stage occupancy states and the packed per-stage payloads.
package pipe_stage_hs_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   // Decode -> execute stage fields, carried as one opaque payload word.
   typedef struct packed {
      logic [7:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [8:0] imm;
   } de_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: +1 per cycle with inc high, sticks at all-ones.
// Latency: count reflects inc one edge later. No backpressure; cleared only by RST.
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !(&count_q)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with sync flush and a saturating stall counter.
// Latency 1 cycle; 1 payload/cycle. With PIPE_STAGE_HS_SKID_EN a skid entry makes
// in_ready a register (no out_ready path); otherwise in_ready follows out_ready.
module pipe_stage_hs
   import pipe_stage_hs_pkg::*;
#(
   parameter int WIDTH     = $bits(de_payload_t),
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLR,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   pipe_state_t      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic             accept;
   logic             emit;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

`ifdef PIPE_STAGE_HS_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             rdy_q, rdy_d;

   // Ready is precomputed from next state so the upstream never sees out_ready.
   assign rdy_d    = (state_d != SKID);
   assign in_ready = rdy_q && !CLR;
`else
   assign in_ready = (!out_valid || out_ready) && !CLR;
`endif

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_STAGE_HS_SKID_EN
      skid_d  = skid_q;
`endif
      if (CLR) begin
         state_d = EMPTY;
         main_d  = '0;
`ifdef PIPE_STAGE_HS_SKID_EN
         skid_d  = '0;
`endif
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = FULL;
                  main_d  = in_data;
               end
            end
            FULL: begin
               if (accept && emit) begin
                  main_d = in_data;
               end else if (emit) begin
                  state_d = EMPTY;
`ifdef PIPE_STAGE_HS_SKID_EN
               end else if (accept) begin
                  state_d = SKID;
                  skid_d  = in_data;
`endif
               end
            end
`ifdef PIPE_STAGE_HS_SKID_EN
            SKID: begin
               if (emit) begin
                  state_d = FULL;
                  main_d  = skid_q;
               end
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= EMPTY;
         main_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

`ifdef PIPE_STAGE_HS_SKID_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         skid_q <= '0;
         rdy_q  <= 1'b1;
      end else begin
         skid_q <= skid_d;
         rdy_q  <= rdy_d;
      end
   end
`endif

   sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_stall_cnt (
      .CLK  (CLK),
      .RST  (RST),
      .inc  (out_valid && !out_ready),
      .count(stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed scenarios then random traffic, scoreboarded against a capacity model.
module tb_pipe_stage_hs;

   localparam int W         = 32;
   localparam int CNT_W     = 4;
   localparam int STALL_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_HS_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             clr_i = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     out_data;
   logic [CNT_W-1:0] stall_cnt;

   pipe_stage_hs #(.WIDTH(W), .CNT_WIDTH(CNT_W)) dut (
      .CLK(clk), .RST(rst_i), .CLR(clr_i),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   logic [W-1:0] sb[$];        // payloads expected downstream, oldest first
   int          occ = 0;       // payloads the stage should be holding
   int          exp_stall = 0;
   bit          exp_zero = 1;  // out_data must read 0 while empty
   logic        took;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      occ = 0;
      exp_stall = 0;
      exp_zero = 1;
   endtask

   // One clock cycle: drive inputs, check cycle-level outputs, advance the model.
   task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                        input logic clr, input logic rst_mid, output logic acc);
      logic exp_rdy;
      logic emt;
      @(negedge clk);
      rst_i = 1'b0;
      in_valid = iv; in_data = id; out_ready = ordy; clr_i = clr;
      #2;
      if (CAP == 2) exp_rdy = !clr && (occ < 2);
      else          exp_rdy = !clr && (occ == 0 || ordy);
      chk("in_ready", W'(in_ready), W'(exp_rdy));
      chk("out_valid", W'(out_valid), W'(occ > 0));
      chk("stall_cnt", W'(stall_cnt), W'(exp_stall));
      if (exp_zero && occ == 0) chk("empty_data_zero", out_data, '0);
      acc = 1'b0;
      if (rst_mid) begin
         #1;
         rst_i = 1'b1; clr_i = 1'b0; in_valid = 1'b0;
         #1;
         chk("rst_out_valid", W'(out_valid), '0);
         chk("rst_out_data", out_data, '0);
         chk("rst_stall_cnt", W'(stall_cnt), '0);
         chk("rst_in_ready", W'(in_ready), W'(1));
         model_reset();
         return;
      end
      acc = iv && exp_rdy;
      emt = (occ > 0) && ordy;
      if (occ > 0 && !ordy && exp_stall < STALL_MAX) exp_stall++;
      if (clr) begin
         occ = 0;
         sb.delete();
         exp_zero = 1;
      end else begin
         if (acc) begin
            sb.push_back(id);
            exp_zero = 0;
         end
         occ = occ + int'(acc) - int'(emt);
      end
   endtask

   // Monitor: data presented downstream must be the oldest outstanding payload.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst_i && out_valid) begin
            if (sb.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL unexpected_output: got %0h expected no valid output", out_data);
            end else begin
               chk("out_data", out_data, sb[0]);
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      logic [W-1:0] d;
      logic         iv, ordy, clr, rm;

      model_reset();
      repeat (3) @(negedge clk);
      #2;
      chk("reset_out_valid", W'(out_valid), '0);
      chk("reset_out_data", out_data, '0);
      chk("reset_stall_cnt", W'(stall_cnt), '0);
      chk("reset_in_ready", W'(in_ready), W'(1));

      // Streaming at full rate.
      for (int i = 1; i <= 3; i++) cycle(1, W'(i), 1, 0, 0, took);
      repeat (2) cycle(0, '0, 1, 0, 0, took);

      // Two payloads against a stalled consumer, then drain.
      cycle(1, 32'hA, 0, 0, 0, took);
      took = 0;
      for (int i = 0; i < 3 && !took; i++) cycle(1, 32'hB, 0, 0, 0, took);
      for (int i = 0; i < 4 && !took; i++) cycle(1, 32'hB, 1, 0, 0, took);
      chk("b_accepted", W'(took), W'(1));
      repeat (3) cycle(0, '0, 1, 0, 0, took);

      // Hold content with out_ready low long enough to saturate, then flush with a payload offered.
      cycle(1, 32'hA, 0, 0, 0, took);
      cycle(1, 32'hB, 0, 0, 0, took);
      repeat (20) cycle(0, '0, 0, 0, 0, took);
      cycle(1, 32'hC, 0, 1, 0, took);
      repeat (2) cycle(0, '0, 0, 0, 0, took);

      // Asynchronous reset mid-stream, then a single payload.
      cycle(1, 32'h11, 0, 0, 0, took);
      cycle(1, 32'h12, 0, 0, 1, took);
      cycle(1, 32'h5, 1, 0, 0, took);
      repeat (2) cycle(0, '0, 1, 0, 0, took);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         iv   = ($urandom_range(99) < 70);
         ordy = ($urandom_range(99) < 60);
         clr  = ($urandom_range(99) < 4);
         rm   = ($urandom_range(999) < 5);
         d    = $urandom;
         cycle(iv, d, ordy, clr, rm, took);
      end
      repeat (4) cycle(0, '0, 1, 0, 0, took);
      chk("final_drained", W'(occ), '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
